fsm_x_driver: RTL and testbench
===============================

# fsm_x_driver

Stimulus transmitter for the one-hot Mealy detector FSM (`fsm`, input `x`, output `Z`). It accepts parallel words over a valid/ready handshake and serializes them MSB-first onto `x`, one bit per clock. It samples the detector's returned `Z` each bit and packs the captured bits into a result word. A cycle-accurate shadow copy of the detector predicts `Z`, so per-word and sticky mismatch flags are produced. It sits between the test/stream source and the detector instance.

## Interface
- `DATA_W`, 8: bits per word, ≥ 2.
- `IDLE_X`, 1'b1: value driven on `x` whenever no word is being shifted.
- `clk`  in  1  clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `in_data`  in  DATA_W  word to transmit.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  high only in IDLE; a transfer occurs on a clock edge with `in_valid && in_ready`.
- `x`  out  1  registered serial bit to the detector.
- `z_in`  in  1  detector `Z`, which is combinational from the detector's state and `x`.
- `out_data`  out  DATA_W  captured `Z` bits; the first bit is the MSB.
- `out_err`  out  1  at least one bit of this word mismatched the prediction.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  result accepted.
- `mismatch`  out  1  sticky OR of all bit mismatches since reset.
- `model_state`  out  4  shadow state, one-hot.

## Operation
- **Shadow model.** Encoding: AC=0001, BD=0010, E=0100, F=1000. It steps on every clock using the current `x`, including during IDLE and DONE.
  - AC: x=1 goes to BD with Z=1; x=0 goes to E with Z=0.
  - BD: x=1 stays BD with Z=0; x=0 goes to F with Z=0.
  - E: x=1 goes to F with Z=1; x=0 goes to AC with Z=0.
  - F: x=1 goes to AC with Z=0; x=0 goes to BD with Z=0.
  - Any illegal code goes to AC with Z=0.
- **Convergence.** With `IDLE_X`=1, any state reaches BD within 3 idle cycles and then holds there.
- **Control FSM:**
  - IDLE: `x`=`IDLE_X`, `in_ready`=1. On accept:
    - load the shift register with `in_data`;
    - set `x` to `in_data[DATA_W-1]`;
    - clear the capture register and the error accumulator;
    - set `count` to 0;
    - go to SHIFT.
  - SHIFT: at each edge, perform all of the following:
    - shift `z_in` into the capture LSB;
    - OR (`z_in` != predicted Z) into the word error and into `mismatch`;
    - advance the shadow model;
    - drive `x` with the next bit;
    - increment `count`.
    
    At the edge that captures bit DATA_W-1:
    - load `out_data` from the full capture;
    - load `out_err`;
    - set `x` to `IDLE_X`;
    - assert `out_valid`;
    - go to DONE.
  - DONE: hold `out_data`, `out_err` and `out_valid` stable. On `out_valid && out_ready`, clear `out_valid` and go to IDLE.
- **No overlap.** `in_ready` is 0 in SHIFT and DONE. There is no back-to-back overlap.
- **Comparison window.** Comparison happens only in SHIFT. Idle cycles never set `mismatch`.
- **Counter.** `count` is $clog2(DATA_W+1) bits wide and does not wrap within a word.

## Timing
- **Reset values:**
  - control state IDLE;
  - `x`=`IDLE_X`;
  - `in_ready`=1;
  - `out_valid`=0, `out_data`=0, `out_err`=0;
  - `mismatch`=0;
  - `model_state`=0001.
- **Accept and shift.** Accept at edge k. Bit i, counted MSB-first, is on `x` during cycle k+1+i, and `z_in` is sampled at the end of that cycle.
- **Result latency.** `out_valid` rises after edge k+DATA_W, i.e. DATA_W+1 cycles after the accept edge. `in_ready` returns the cycle after the handshake completes.
- **Reset mid-word.** Reset abandons the word: there is no `out_valid`, `x` returns to `IDLE_X`, and the shadow returns to AC. The detector is reset by the same `reset`.
- **No backpressure into SHIFT.** `out_ready` has no effect outside DONE.

## Test plan
- **Reference word.** Release reset, idle 4 cycles so the state is BD, send 0x55 with a correct detector on `z_in`:
  - `out_data`=0x10, `out_err`=0, `mismatch`=0;
  - `model_state`=0001 at DONE entry;
  - `out_valid` exactly 9 cycles after accept.
- **Second word.** After ≥3 idle cycles, send 0x2A:
  - `out_data`=0x02, `out_err`=0;
  - `x` sequence equals 0,0,1,0,1,0,1,0 on consecutive cycles.
- **Injected fault.** Force `z_in`=0 and send 0x55 from BD:
  - `out_data`=0x00, `out_err`=1, `mismatch`=1;
  - `mismatch` stays 1 after the next, clean word, and that word reports `out_err`=0.
- **Backpressure.** Hold `out_ready`=0 for 5 cycles in DONE:
  - `out_valid`, `out_data` and `out_err` are stable;
  - `in_ready`=0, even with `in_valid` asserted;
  - `x`=1.
  - Then pulse `out_ready`: `in_ready`=1 on the next cycle.
- **Reset mid-word.** Assert `reset` after 3 bits of 0xFF:
  - immediately `x`=1, `out_valid`=0, `model_state`=0001, `in_ready`=1;
  - the next word completes normally.
- **Illegal state.** Force the shadow state to 0110 via a hierarchical deposit: the next step gives `model_state`=0001 with predicted Z=0.

Source files
------------

// File: rtl/fsm_x_driver.sv
`timescale 1ns/1ps
// fsm_x_driver: serial stimulus transmitter for the one-hot Mealy detector.
// Accepts words over in_valid/in_ready and shifts them MSB-first onto x, one
// bit per clock. Captures the detector's z_in per bit into out_data. A shadow
// copy of the detector predicts Z, which drives the per-word out_err flag and
// the sticky mismatch flag.
// Ports:
//   clk, reset                      clock, async active-high reset
//   in_data, in_valid, in_ready     word input handshake (ready only in IDLE)
//   x                               registered serial bit to the detector
//   z_in                            detector Z (combinational in the detector)
//   out_data, out_err, out_valid    captured word, error flag, result valid
//   out_ready                       result accepted
//   mismatch                        sticky OR of all bit mismatches
//   model_state                     shadow detector state, one-hot
module fsm_x_driver #(
    parameter int unsigned DATA_W = 8,
    parameter logic        IDLE_X = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              x,
    input  logic              z_in,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              mismatch,
    output logic [3:0]        model_state
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    localparam logic [3:0] ST_AC = 4'b0001;
    localparam logic [3:0] ST_BD = 4'b0010;
    localparam logic [3:0] ST_E  = 4'b0100;
    localparam logic [3:0] ST_F  = 4'b1000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } ctrl_t;

    ctrl_t             ctrl;
    logic [DATA_W-2:0] shreg;     // bits still to be sent after the one on x
    logic [DATA_W-2:0] cap;       // Z bits captured so far in this word
    logic              err_acc;
    logic [CNT_W-1:0]  count;

    logic [3:0]        model_next;
    logic              pred_z;
    logic              bit_mm;
    logic [DATA_W-1:0] cap_next;
    logic              err_next;

    // Shadow detector: next state and predicted Mealy output from state and x.
    always_comb begin
        model_next = ST_AC;
        pred_z     = 1'b0;
        case (model_state)
            ST_AC: begin
                model_next = x ? ST_BD : ST_E;
                pred_z     = x;
            end
            ST_BD: model_next = x ? ST_BD : ST_F;
            ST_E: begin
                model_next = x ? ST_F : ST_AC;
                pred_z     = x;
            end
            ST_F:  model_next = x ? ST_AC : ST_BD;
            default: begin
                model_next = ST_AC;
                pred_z     = 1'b0;
            end
        endcase
    end

    // Per-bit capture and error terms used during SHIFT.
    always_comb begin
        bit_mm   = z_in ^ pred_z;
        cap_next = {cap, z_in};
        err_next = err_acc | bit_mm;
    end

    // Control FSM, shift/capture datapath and shadow state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl        <= IDLE;
            x           <= IDLE_X;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_err     <= 1'b0;
            mismatch    <= 1'b0;
            model_state <= ST_AC;
            shreg       <= '0;
            cap         <= '0;
            err_acc     <= 1'b0;
            count       <= '0;
        end else begin
            // The shadow steps every clock so it tracks the detector in idle too.
            model_state <= model_next;
            case (ctrl)
                IDLE: begin
                    x <= IDLE_X;
                    if (in_valid && in_ready) begin
                        shreg    <= in_data[DATA_W-2:0];
                        x        <= in_data[DATA_W-1];
                        cap      <= '0;
                        err_acc  <= 1'b0;
                        count    <= '0;
                        in_ready <= 1'b0;
                        ctrl     <= SHIFT;
                    end
                end
                SHIFT: begin
                    cap      <= cap_next[DATA_W-2:0];
                    err_acc  <= err_next;
                    mismatch <= mismatch | bit_mm;
                    shreg    <= shreg << 1;
                    x        <= shreg[DATA_W-2];
                    count    <= count + CNT_W'(1);
                    if (count == CNT_W'(DATA_W - 1)) begin
                        out_data  <= cap_next;
                        out_err   <= err_next;
                        x         <= IDLE_X;
                        out_valid <= 1'b1;
                        ctrl      <= DONE;
                    end
                end
                DONE: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        ctrl      <= IDLE;
                    end
                end
                default: begin
                    ctrl     <= IDLE;
                    x        <= IDLE_X;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fsm_x_driver.sv
`timescale 1ns/1ps
// tb_fsm_x_driver: directed bench for fsm_x_driver with a behavioural copy of
// the detector driving z_in (optionally forced to 0 to inject a fault).
module tb_fsm_x_driver;

    localparam int unsigned DATA_W = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              x;
    logic              z_in;
    logic [DATA_W-1:0] out_data;
    logic              out_err;
    logic              out_valid;
    logic              out_ready;
    logic              mismatch;
    logic [3:0]        model_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fsm_x_driver #(.DATA_W(DATA_W), .IDLE_X(1'b1)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .x          (x),
        .z_in       (z_in),
        .out_data   (out_data),
        .out_err    (out_err),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .mismatch   (mismatch),
        .model_state(model_state)
    );

    // Behavioural detector standing in for the real fsm instance.
    typedef enum logic [1:0] {D_AC, D_BD, D_E, D_F} det_t;
    det_t det;
    logic force_zero;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) det <= D_AC;
        else begin
            case (det)
                D_AC: det <= x ? D_BD : D_E;
                D_BD: det <= x ? D_BD : D_F;
                D_E:  det <= x ? D_F  : D_AC;
                default: det <= x ? D_AC : D_BD;
            endcase
        end
    end

    assign z_in = force_zero ? 1'b0 : (x & ((det == D_AC) | (det == D_E)));

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Sends one word; returns x per bit (MSB-first packed), edges from accept
    // to out_valid, and a timeout flag. Leaves out_ready low.
    task automatic run_word(input logic [7:0] w, output logic [7:0] xs,
                            output int lat, output bit to);
        bit acc;
        acc = 1'b0;
        to  = 1'b0;
        lat = 0;
        xs  = '0;
        in_data  = w;
        in_valid = 1'b1;
        for (int i = 0; i < 20 && !acc; i++) begin
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!acc) begin
            to = 1'b1;
            return;
        end
        while (!out_valid && lat < 40) begin
            if (lat < 8) xs[7-lat] = x;
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid) to = 1'b1;
    endtask

    task automatic ack();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; force_zero = 1'b0;
        idle(2);
        checks++; if (x !== 1'b1) begin errors++; $display("FAIL reset_x got %b exp 1", x); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %h exp 00", out_data); end
        checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL reset_out_err got %b exp 0", out_err); end
        checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL reset_mismatch got %b exp 0", mismatch); end
        checks++; if (model_state !== 4'b0001) begin errors++; $display("FAIL reset_model_state got %b exp 0001", model_state); end
        reset = 1'b0;
    endtask

    // 0x55 from BD: Z = 0,0,0,1,0,0,0,0 -> 0x10, ending in AC.
    task automatic test_reference();
        logic [7:0] xs; int lat; bit to;
        idle(4);
        run_word(8'h55, xs, lat, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL ref_timeout got %b exp 0", to); end
        checks++; if (out_data !== 8'h10) begin errors++; $display("FAIL ref_out_data got %h exp 10", out_data); end
        checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL ref_out_err got %b exp 0", out_err); end
        checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL ref_mismatch got %b exp 0", mismatch); end
        checks++; if (model_state !== 4'b0001) begin errors++; $display("FAIL ref_model_state got %b exp 0001", model_state); end
        // Cycle after the accept edge is cycle 1; out_valid must first show in cycle 9.
        checks++; if (lat + 1 !== 9) begin errors++; $display("FAIL ref_latency got %0d exp 9", lat + 1); end
        ack();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ref_ack_valid got %b exp 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ref_ack_ready got %b exp 1", in_ready); end
    endtask

    // 0x2A from BD: Z only on bit 6 -> 0x02.
    task automatic test_second_word();
        logic [7:0] xs; int lat; bit to;
        idle(3);
        run_word(8'h2A, xs, lat, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL w2_timeout got %b exp 0", to); end
        checks++; if (out_data !== 8'h02) begin errors++; $display("FAIL w2_out_data got %h exp 02", out_data); end
        checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL w2_out_err got %b exp 0", out_err); end
        checks++; if (xs !== 8'b00101010) begin errors++; $display("FAIL w2_x_seq got %b exp 00101010", xs); end
        ack();
    endtask

    task automatic test_fault();
        logic [7:0] xs; int lat; bit to;
        force_zero = 1'b1;
        idle(3);
        run_word(8'h55, xs, lat, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL fault_timeout got %b exp 0", to); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL fault_out_data got %h exp 00", out_data); end
        checks++; if (out_err !== 1'b1) begin errors++; $display("FAIL fault_out_err got %b exp 1", out_err); end
        checks++; if (mismatch !== 1'b1) begin errors++; $display("FAIL fault_mismatch got %b exp 1", mismatch); end
        ack();
        force_zero = 1'b0;
        idle(3);
        run_word(8'h2A, xs, lat, to);
        checks++; if (out_data !== 8'h02) begin errors++; $display("FAIL clean_out_data got %h exp 02", out_data); end
        checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL clean_out_err got %b exp 0", out_err); end
        checks++; if (mismatch !== 1'b1) begin errors++; $display("FAIL sticky_mismatch got %b exp 1", mismatch); end
        ack();
    endtask

    task automatic test_backpressure();
        logic [7:0] xs; int lat; bit to;
        idle(3);
        run_word(8'h55, xs, lat, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL bp_timeout got %b exp 0", to); end
        in_data  = 8'hA5;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid c%0d got %b exp 1", c, out_valid); end
            checks++; if (out_data !== 8'h10) begin errors++; $display("FAIL bp_data c%0d got %h exp 10", c, out_data); end
            checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL bp_err c%0d got %b exp 0", c, out_err); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready c%0d got %b exp 0", c, in_ready); end
            checks++; if (x !== 1'b1) begin errors++; $display("FAIL bp_x c%0d got %b exp 1", c, x); end
        end
        in_valid = 1'b0;
        ack();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got %b exp 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_reset_mid_word();
        logic [7:0] xs; int lat; bit to;
        idle(3);
        in_data  = 8'hFF;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_accepted got %b exp 0", in_ready); end
        idle(3);
        reset = 1'b1;
        #1;
        checks++; if (x !== 1'b1) begin errors++; $display("FAIL mid_x got %b exp 1", x); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid got %b exp 0", out_valid); end
        checks++; if (model_state !== 4'b0001) begin errors++; $display("FAIL mid_model_state got %b exp 0001", model_state); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready got %b exp 1", in_ready); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(4);
        run_word(8'h55, xs, lat, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL mid_next_timeout got %b exp 0", to); end
        checks++; if (out_data !== 8'h10) begin errors++; $display("FAIL mid_next_data got %h exp 10", out_data); end
        checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL mid_next_err got %b exp 0", out_err); end
        checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL mid_next_mismatch got %b exp 0", mismatch); end
        ack();
    endtask

    task automatic test_illegal_state();
        logic [7:0] xs; int lat; bit to;
        idle(2);
        dut.model_state = 4'b0110;
        #1;
        checks++; if (dut.pred_z !== 1'b0) begin errors++; $display("FAIL illegal_pred_z got %b exp 0", dut.pred_z); end
        @(posedge clk);
        #1;
        checks++; if (model_state !== 4'b0001) begin errors++; $display("FAIL illegal_next got %b exp 0001", model_state); end
        idle(4);
        run_word(8'h55, xs, lat, to);
        checks++; if (out_data !== 8'h10) begin errors++; $display("FAIL illegal_recover_data got %h exp 10", out_data); end
        checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL illegal_recover_err got %b exp 0", out_err); end
        ack();
    endtask

    initial begin
        test_reset();
        test_reference();
        test_second_word();
        test_fault();
        test_backpressure();
        test_reset_mid_word();
        test_illegal_state();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
